// File: rtl/wavegen_multi_axis.sv
// Multi-channel DDS waveform source (saw/triangle/square/LFSR noise) with AXI-Stream master output.
// Two-stage pipeline; acc and LFSR advance only when the output register can accept a new beat.
module wavegen_multi_axis #(
  parameter int          DW        = 16,
  parameter int          NCH       = 2,
  parameter int          PW        = 32,
  parameter logic [31:0] LFSR_SEED = 32'hACE12B3D
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                en_i,
  input  logic [1:0]          mode_i,
  input  logic [PW-1:0]       phase_inc_i,
  input  logic [NCH*PW-1:0]   phase_ofs_i,
  input  logic [DW-1:0]       amp_i,
  input  logic                rand_amp_en_i,
  output logic [NCH*DW-1:0]   tdata_m_o,
  output logic                tvalid_m_o,
  input  logic                tready_m_i,
  output logic                tlast_m_o
);

  typedef enum logic [1:0] {SAW, TRI, SQR, NOISE} mode_e;

  localparam logic [31:0]   SEED      = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
  localparam logic [DW-1:0] POS_FS    = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] NEG_FS    = {1'b1, {(DW-2){1'b0}}, 1'b1};
  localparam logic [DW-1:0] AMP_FLOOR = {2'b01, {(DW-2){1'b0}}};

  logic                ce;
  mode_e               mode;
  logic [PW-1:0]       acc;
  logic [PW:0]         acc_sum;
  logic [31:0]         lfsr;
  logic [31:0]         lfsr_nxt;
  logic                v1;
  logic                last1;
  logic [NCH*DW-1:0]   raw;
  logic [NCH*DW-1:0]   raw_nxt;
  logic [NCH*DW-1:0]   scaled;
  logic [DW-1:0]       amp_eff;
  logic                sign_q;
  logic                zc_cnt;
  logic                sign_chg;

  logic [PW-1:0]       p;
  logic [DW-1:0]       t;
  logic [DW-1:0]       u;
  logic [DW-1:0]       s;
  logic [63:0]         rot;
  logic signed [2*DW:0] mul_a;
  logic signed [2*DW:0] mul_b;
  logic signed [2*DW:0] prod;

  assign ce       = !tvalid_m_o || tready_m_i;
  assign mode     = mode_e'(mode_i);
  assign acc_sum  = {1'b0, acc} + {1'b0, phase_inc_i};
  assign lfsr_nxt = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
  assign sign_chg = v1 && (raw[DW-1] != sign_q);

  always_comb begin
    raw_nxt = '0;
    p       = '0;
    t       = '0;
    u       = '0;
    s       = '0;
    rot     = '0;
    for (int k = 0; k < NCH; k++) begin
      p   = acc + phase_ofs_i[k*PW +: PW];
      t   = p[PW-1 -: DW];
      u   = p[PW-2 -: DW];
      // Each channel sees the LFSR rotated by a different amount so channels are decorrelated
      rot = {lfsr, lfsr} << ((7 * k) % 32);
      case (mode)
        SAW:     s = {~t[DW-1], t[DW-2:0]};
        TRI:     s = (p[PW-1] ? ~u : u) ^ {1'b1, {(DW-1){1'b0}}};
        SQR:     s = p[PW-1] ? NEG_FS : POS_FS;
        default: s = rot[32 +: DW];
      endcase
      raw_nxt[k*DW +: DW] = s;
    end
  end

  // Signed sample times unsigned amplitude; the upper half of the product is the floored >>> DW
  always_comb begin
    scaled = '0;
    mul_a  = '0;
    mul_b  = '0;
    prod   = '0;
    for (int k = 0; k < NCH; k++) begin
      mul_a = {{(DW+1){raw[k*DW+DW-1]}}, raw[k*DW +: DW]};
      mul_b = {{(DW+1){1'b0}}, amp_eff};
      prod  = mul_a * mul_b;
      scaled[k*DW +: DW] = prod[DW +: DW];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc        <= '0;
      lfsr       <= SEED;
      v1         <= 1'b0;
      last1      <= 1'b0;
      raw        <= '0;
      tvalid_m_o <= 1'b0;
      tlast_m_o  <= 1'b0;
      tdata_m_o  <= '0;
      amp_eff    <= '1;
      sign_q     <= 1'b0;
      zc_cnt     <= 1'b0;
    end else if (ce) begin
      v1    <= en_i;
      last1 <= en_i && acc_sum[PW];
      raw   <= raw_nxt;
      if (en_i) begin
        acc  <= acc_sum[PW-1:0];
        lfsr <= lfsr_nxt;
      end
      tvalid_m_o <= v1;
      tlast_m_o  <= last1;
      tdata_m_o  <= scaled;
      if (v1) sign_q <= raw[DW-1];
      if (sign_chg) zc_cnt <= ~zc_cnt;
      // Two sign changes of channel 0 make one full period
      if (!rand_amp_en_i) amp_eff <= amp_i;
      else if (sign_chg && zc_cnt) amp_eff <= lfsr[DW-1:0] | AMP_FLOOR;
    end
  end

endmodule

// File: doc/wavegen_multi_axis.md
Name: wavegen_multi_axis

Overview:
Synthesizable multi-channel periodic and noise waveform source with an AXI-Stream master output, used as a stimulus generator in testbenches and on-chip self-test. A shared DDS phase accumulator drives NCH channels, each with its own phase offset. Supported waveforms are sawtooth, triangle, square and LFSR noise. Amplitude is either fixed or randomised once per period. Unlike earlier generators, it honours tready, emits tlast, and uses no real arithmetic.

Parameters:
DW, 16, sample width per channel (signed), 4..32
NCH, 2, number of channels packed into one beat, 1..8
PW, 32, phase accumulator width, PW >= DW+1
LFSR_SEED, 32'hACE12B3D, initial LFSR state (value 0 replaced by 1)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
en_i  in  1  run enable
mode_i  in  2  0=saw, 1=triangle, 2=square, 3=noise
phase_inc_i  in  PW  phase increment per accepted sample
phase_ofs_i  in  NCH*PW  per-channel phase offset, channel k at [k*PW +: PW]
amp_i  in  DW  unsigned amplitude, all-ones ~= unity
rand_amp_en_i  in  1  1 = amplitude taken from LFSR once per period
tdata_m_o  out  NCH*DW  samples, channel k at [k*DW +: DW], two's complement
tvalid_m_o  out  1  AXIS valid
tready_m_i  in  1  AXIS ready
tlast_m_o  out  1  marks last sample of a channel-0 period

Behaviour:
- Reset is asynchronous and active-low on aresetn; clock is aclk.
- Reset values: tdata 0, tvalid 0, tlast 0, acc 0, lfsr LFSR_SEED, amp_eff all-ones, stage-1 valid 0, zero-crossing count 0, sign state 0.
- Pipeline advance: ce = !tvalid_m_o || tready_m_i. All stages update only when ce=1.
- Stage 1, when ce:
  - v1 <= en_i.
  - If en_i: acc <= acc + phase_inc_i (mod 2^PW) and the LFSR steps once.
  - Per channel: p_k = acc + ofs_k (mod 2^PW), t = p_k[PW-1 -: DW], u = p_k[PW-2 -: DW].
  - saw = t with MSB inverted.
  - tri = (p_k[PW-1] ? ~u : u) with MSB inverted.
  - sq = p_k[PW-1] ? -(2^(DW-1)-1) : +(2^(DW-1)-1).
  - noise = lower DW bits of LFSR rotated left by 7*k.
  - The last1 flag is set if acc + phase_inc_i carries out of PW bits.
  - mode_i and the offsets are sampled here.
- Stage 2, when ce:
  - tvalid <= v1, tlast <= last1.
  - tdata_k <= (raw_k * amp_eff) >>> DW, computed as a signed DW by unsigned DW product with floor truncation.
  - If rand_amp_en_i=0, amp_eff is taken from amp_i on every ce.
- Latency: the first tvalid appears 2 cycles after en_i is first sampled high with tready=1.
- Backpressure: while tvalid=1 and tready=0, tdata and tlast are held stable and acc/LFSR do not move. No sample is dropped or duplicated.
- en_i low: acc freezes and v1 becomes 0. Samples already in flight drain normally; tvalid falls only after acceptance. Re-enabling continues from the frozen acc.
- LFSR: 32-bit Fibonacci, taps 32,22,2,1, shift left, feedback into bit 0.
- Random amplitude:
  - Sign state tracks the ch0 raw MSB on each stage-1 advance with v1=1.
  - Each sign change increments a 1-bit counter.
  - When the counter wraps (every 2nd change, i.e. one full period), amp_eff <= LFSR[DW-1:0] | 2^(DW-2). The OR sets a minimum amplitude of 1/4.
  - amp_eff is otherwise held.
- Mode change mid-stream takes effect on the next stage-1 advance. No reset of acc.
- phase_inc_i = 0: constant output; tlast never asserts.
- Mid-operation reset: outputs clear immediately regardless of tready, and the pipeline contents are discarded.

Test Plan:
1. Hold aresetn low, then release with en_i=1 and tready=1 -> tvalid=0 and tdata=0 during reset; first tvalid on the 2nd rising edge after release.
2. Saw, DW=16, PW=32, phase_inc=2^28, amp=16'hFFFF, ofs=0 -> ch0 = -32768, -28672, ..., -4096, 0, 4095, 8191, ..., 28671 repeating. tlast=1 only on the 28671 beat.
3. Same stream with tready low for 5 cycles at beat 7 -> tdata, tvalid, tlast stable during the stall; the accepted sequence is identical to test 2.
4. Square, ch1 offset 2^31, amp=16'hFFFF -> every beat ch0=+32766 and ch1=-32767, or the reverse; the pattern flips every 8 beats with phase_inc=2^28.
5. Triangle with rand_amp_en_i=1 -> amp_eff changes exactly once per 16 beats, at the 2nd ch0 sign change. Each value matches the reference LFSR model and has bit DW-2 set.
6. Assert aresetn low while tvalid=1 and tready=0, then rerun test 2 -> outputs zero immediately; the post-reset sequence reproduces test 2 exactly, and noise mode restarts from LFSR_SEED.
